// File: rtl/pause_frame_tx.sv
// 802.3x MAC Control PAUSE frame generator: XOFF on request, periodic refresh XOFF, optional XON on release.
// Optional XON support is compiled in by defining PAUSE_FRAME_TX_XON_EN.
module pause_frame_tx #(
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter logic [31:0] REFRESH_CYCLES = 32'd100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inject_pause_in,
  input  logic [47:0] src_mac_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  output logic        tx_last_out,
  input  logic        tx_ready_in,
  output logic        pause_active_out,
  output logic        busy_out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        sent_q;
  logic        xon_q;
  logic [31:0] refresh_q;
  logic [47:0] mac_q;
  logic [15:0] quanta_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        last_q;

  logic [5:0]  cnt_nxt_d;
  logic [7:0]  byte_nxt_d;
  logic        xfer_d;
  logic        start_xoff_d;

  // Byte following the current one; byte 0 is loaded directly at frame start.
  always_comb begin
    cnt_nxt_d    = cnt_q + 6'd1;
    xfer_d       = valid_q & tx_ready_in;
    start_xoff_d = inject_pause_in && (!sent_q || (refresh_q == 32'd0));
    case (cnt_nxt_d)
      6'd1:    byte_nxt_d = 8'h80;
      6'd2:    byte_nxt_d = 8'hC2;
      6'd3:    byte_nxt_d = 8'h00;
      6'd4:    byte_nxt_d = 8'h00;
      6'd5:    byte_nxt_d = 8'h01;
      6'd6:    byte_nxt_d = mac_q[47:40];
      6'd7:    byte_nxt_d = mac_q[39:32];
      6'd8:    byte_nxt_d = mac_q[31:24];
      6'd9:    byte_nxt_d = mac_q[23:16];
      6'd10:   byte_nxt_d = mac_q[15:8];
      6'd11:   byte_nxt_d = mac_q[7:0];
      6'd12:   byte_nxt_d = 8'h88;
      6'd13:   byte_nxt_d = 8'h08;
      6'd14:   byte_nxt_d = 8'h00;
      6'd15:   byte_nxt_d = 8'h01;
      6'd16:   byte_nxt_d = quanta_q[15:8];
      6'd17:   byte_nxt_d = quanta_q[7:0];
      default: byte_nxt_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      sent_q    <= 1'b0;
      xon_q     <= 1'b0;
      refresh_q <= 32'd0;
      mac_q     <= 48'd0;
      quanta_q  <= 16'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_xoff_d) begin
            state_q  <= SEND;
            cnt_q    <= 6'd0;
            data_q   <= 8'h01;
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            mac_q    <= src_mac_in;
            quanta_q <= PAUSE_QUANTA;
            sent_q   <= 1'b1;
            xon_q    <= 1'b0;
`ifdef PAUSE_FRAME_TX_XON_EN
          end else if (!inject_pause_in && sent_q) begin
            state_q   <= SEND;
            cnt_q     <= 6'd0;
            data_q    <= 8'h01;
            valid_q   <= 1'b1;
            last_q    <= 1'b0;
            mac_q     <= src_mac_in;
            quanta_q  <= 16'h0000;
            sent_q    <= 1'b0;
            xon_q     <= 1'b1;
            refresh_q <= 32'd0;
`else
          end else if (!inject_pause_in && sent_q) begin
            // Without XON the partner's pause timer simply expires.
            sent_q    <= 1'b0;
            refresh_q <= 32'd0;
`endif
          end else if (refresh_q != 32'd0) begin
            refresh_q <= refresh_q - 32'd1;
          end
        end
        SEND: begin
          if (xfer_d) begin
            if (cnt_q == 6'd59) begin
              state_q <= IDLE;
              cnt_q   <= 6'd0;
              data_q  <= 8'h00;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (!xon_q) refresh_q <= REFRESH_CYCLES - 32'd1;
            end else begin
              cnt_q  <= cnt_nxt_d;
              data_q <= byte_nxt_d;
              last_q <= (cnt_nxt_d == 6'd59);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data_out      = data_q;
  assign tx_valid_out     = valid_q;
  assign tx_last_out      = last_q;
  assign pause_active_out = sent_q;
  assign busy_out         = (state_q == SEND);

endmodule

// File: tb/tb_pause_frame_tx.sv
// Directed bench for pause_frame_tx: expected frame table plus hand-written refresh, release, pulse and reset sequences.
module tb_pause_frame_tx;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        inject_pause_in = 1'b0;
  logic [47:0] src_mac_in = 48'h0A0B0C0D0E0F;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_last_out;
  logic        tx_ready_in = 1'b1;
  logic        pause_active_out;
  logic        busy_out;

  pause_frame_tx #(
    .PAUSE_QUANTA  (16'hFFFF),
    .REFRESH_CYCLES(32'd10)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .inject_pause_in (inject_pause_in),
    .src_mac_in      (src_mac_in),
    .tx_data_out     (tx_data_out),
    .tx_valid_out    (tx_valid_out),
    .tx_last_out     (tx_last_out),
    .tx_ready_in     (tx_ready_in),
    .pause_active_out(pause_active_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } vec_t;

  localparam logic [143:0] HDR = 144'h0180C2000001_0A0B0C0D0E0F_8808_0001_FFFF;

  vec_t exp_tab[60];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Receives one frame against exp_tab; optionally toggles ready and pulses inject low mid-frame.
  task automatic recv_frame(input bit toggle, input int pulse_at, input int pulse_len, output int cycles);
    int idx;
    int wait_c;
    bit rdy;
    idx = 0;
    wait_c = 0;
    cycles = 0;
    while (!tx_valid_out && wait_c < 200) begin
      step();
      wait_c++;
    end
    if (!tx_valid_out) begin
      chk("frame_start_timeout", 32'(tx_valid_out), 32'd1);
      return;
    end
    rdy = toggle ? 1'b0 : 1'b1;
    while (idx < 60 && cycles < 300) begin
      if (cycles == pulse_at) inject_pause_in = 1'b0;
      if (cycles == pulse_at + pulse_len) inject_pause_in = 1'b1;
      tx_ready_in = rdy;
      cycles++;
      chk("valid_in_frame", 32'(tx_valid_out), 32'd1);
      chk("busy_in_frame", 32'(busy_out), 32'd1);
      chk($sformatf("byte%0d", idx), 32'(tx_data_out), 32'(exp_tab[idx].data));
      chk($sformatf("last%0d", idx), 32'(tx_last_out), 32'(exp_tab[idx].last));
      if (rdy && tx_valid_out) idx++;
      step();
      if (toggle) rdy = !rdy;
    end
    tx_ready_in = 1'b1;
    n_frames++;
    $display("frame %0d: %0d bytes in %0d cycles (quanta %02h%02h)", n_frames, idx, cycles,
             exp_tab[16].data, exp_tab[17].data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gap;
    int vcount;

    for (int i = 0; i < 60; i++) begin
      exp_tab[i].data = 8'h00;
      exp_tab[i].last = (i == 59);
    end
    for (int i = 0; i < 18; i++) exp_tab[i].data = HDR[143-8*i -: 8];

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(tx_valid_out), 32'd0);
    chk("rst_data", 32'(tx_data_out), 32'd0);
    chk("rst_last", 32'(tx_last_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_pause", 32'(pause_active_out), 32'd0);
    rst_in = 1'b0;
    step();
    chk("idle_valid", 32'(tx_valid_out), 32'd0);

    // First XOFF: one-cycle latency, full-rate frame
    inject_pause_in = 1'b1;
    step();
    chk("latency_valid", 32'(tx_valid_out), 32'd1);
    chk("latency_byte0", 32'(tx_data_out), 32'h01);
    chk("latency_pause", 32'(pause_active_out), 32'd1);
    recv_frame(1'b0, -1, 0, cyc);
    chk("frame1_cycles", 32'(cyc), 32'd60);
    chk("frame1_end_valid", 32'(tx_valid_out), 32'd0);
    chk("frame1_end_busy", 32'(busy_out), 32'd0);
    chk("frame1_pause", 32'(pause_active_out), 32'd1);

    // Refresh gap, then the refresh frame under ready toggling
    gap = 0;
    while (!tx_valid_out && gap < 50) begin
      step();
      gap++;
    end
    chk("refresh_gap1", 32'(gap), 32'd10);
    recv_frame(1'b1, -1, 0, cyc);
    chk("stall_cycles", 32'(cyc), 32'd120);
    chk("frame2_end_valid", 32'(tx_valid_out), 32'd0);

    // Release the request
    inject_pause_in = 1'b0;
    chk("release_pause_before", 32'(pause_active_out), 32'd1);
    step();
    chk("release_pause_after", 32'(pause_active_out), 32'd0);
`ifdef PAUSE_FRAME_TX_XON_EN
    chk("xon_start_valid", 32'(tx_valid_out), 32'd1);
    exp_tab[16].data = 8'h00;
    exp_tab[17].data = 8'h00;
    recv_frame(1'b0, -1, 0, cyc);
    chk("xon_cycles", 32'(cyc), 32'd60);
    exp_tab[16].data = 8'hFF;
    exp_tab[17].data = 8'hFF;
    chk("xon_end_pause", 32'(pause_active_out), 32'd0);
`endif
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_valid_out) vcount++;
      step();
    end
    chk("released_no_frames", 32'(vcount), 32'd0);

    // Short low pulse mid-frame: frame intact, no XON, next frame is a refresh
    inject_pause_in = 1'b1;
    recv_frame(1'b0, 20, 3, cyc);
    chk("pulse_frame_cycles", 32'(cyc), 32'd60);
    chk("pulse_pause", 32'(pause_active_out), 32'd1);
    gap = 0;
    while (!tx_valid_out && gap < 50) begin
      step();
      gap++;
    end
    chk("refresh_gap_after_pulse", 32'(gap), 32'd10);
    chk("refresh_is_xoff_pause", 32'(pause_active_out), 32'd1);

    // Asynchronous reset at byte 30
    for (int i = 0; i < 30; i++) step();
    chk("pre_rst_valid", 32'(tx_valid_out), 32'd1);
    chk("pre_rst_byte30", 32'(tx_data_out), 32'h00);
    chk("pre_rst_busy", 32'(busy_out), 32'd1);
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst_valid", 32'(tx_valid_out), 32'd0);
    chk("async_rst_busy", 32'(busy_out), 32'd0);
    chk("async_rst_pause", 32'(pause_active_out), 32'd0);
    chk("async_rst_last", 32'(tx_last_out), 32'd0);
    step();
    step();
    rst_in = 1'b0;
    recv_frame(1'b0, -1, 0, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd60);
    chk("post_rst_pause", 32'(pause_active_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
